// File: rtl/light_sensor_pkg.sv
// Shared definitions for the light sensor bank.
// Holds the latency-timer state encoding and the default values of the
// bank parameters so that the top and any wrapper agree on them.
package light_sensor_pkg;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_COUNT = 2'd1,
    T_DONE  = 2'd2
  } timer_state_t;

  localparam int DEF_CHANNELS        = 2;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_COUNT_W         = 24;

endpackage

// File: rtl/light_sensor_channel.sv
// One sensor channel: synchroniser chain, debounce filter and edge pulses.
// Ports:
//   clk     - system clock
//   resetn  - asynchronous active-low reset
//   sensor  - raw asynchronous sensor level
//   on      - debounced level
//   rise    - one-cycle pulse in the cycle on first shows 1
//   fall    - one-cycle pulse in the cycle on first shows 0
module light_sensor_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic sensor,
  output logic on,
  output logic rise,
  output logic fall
);

  // Stage p0: plain flop chain, bit 0 is the first stage.
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_p0;
  logic synced;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sensor};
    end
  end

  assign synced = sync_p0[SYNC_STAGES-1];

  // Stage p1: debounce filter and edge pulses.
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign on = synced;

      // on follows the last stage directly, so the edge is visible one stage
      // earlier: the next value of on is already sitting in the stage before.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          rise <= 1'b0;
          fall <= 1'b0;
        end else begin
          rise <= sync_p0[SYNC_STAGES-2] & ~synced;
          fall <= ~sync_p0[SYNC_STAGES-2] & synced;
        end
      end
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] db_cnt_p1;
      logic             on_p1;

      // The counter holds the number of differing cycles already seen; on
      // flips at the end of the DEBOUNCE_CYCLES-th consecutive one.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          db_cnt_p1 <= '0;
          on_p1     <= 1'b0;
          rise      <= 1'b0;
          fall      <= 1'b0;
        end else begin
          rise <= 1'b0;
          fall <= 1'b0;
          if (synced != on_p1) begin
            if (db_cnt_p1 == LAST) begin
              on_p1     <= synced;
              db_cnt_p1 <= '0;
              rise      <= synced;
              fall      <= ~synced;
            end else begin
              db_cnt_p1 <= db_cnt_p1 + 1'b1;
            end
          end else begin
            db_cnt_p1 <= '0;
          end
        end
      end

      assign on = on_p1;
    end
  endgenerate

endmodule

// File: rtl/light_sensor_bank.sv
// Bank of debounced light sensors with a single rise-latency timer.
// Ports:
//   clk, resetn         - clock and asynchronous active-low reset
//   sensor[CHANNELS]    - raw asynchronous sensor levels
//   on/rise/fall        - debounced level and edge pulses per channel
//   start, chan_sel     - request one latency measurement on a channel
//   busy                - measurement running or result pending
//   result_valid/ready  - result handshake
//   result_count        - cycles from start to the selected channel's rise
//   result_timeout      - counter saturated or channel select out of range
module light_sensor_bank
  import light_sensor_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COUNT_W         = DEF_COUNT_W,
  localparam int SEL_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [CHANNELS-1:0] sensor,
  output logic [CHANNELS-1:0] on,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  input  logic               start,
  input  logic [SEL_W-1:0]   chan_sel,
  output logic               busy,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [COUNT_W-1:0] result_count,
  output logic               result_timeout
);

  // Channel filters run regardless of the timer state.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    light_sensor_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .sensor (sensor[i]),
      .on     (on[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  function automatic logic sat_hit(input logic [COUNT_W-1:0] v);
    return v == '1;
  endfunction

  timer_state_t       state;
  logic [SEL_W-1:0]   sel_q;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] count_inc;

  assign count_inc = count + 1'b1;

  // The first COUNT cycle holds count=0, so a rise seen there reports 1;
  // the start cycle itself is spent in IDLE and cannot see a rise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= T_IDLE;
      sel_q          <= '0;
      count          <= '0;
      result_count   <= '0;
      result_timeout <= 1'b0;
      result_valid   <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        T_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (32'(chan_sel) < CHANNELS) begin
              sel_q <= chan_sel;
              count <= '0;
              state <= T_COUNT;
            end else begin
              result_count   <= '0;
              result_timeout <= 1'b1;
              result_valid   <= 1'b1;
              state          <= T_DONE;
            end
          end
        end
        T_COUNT: begin
          if (rise[sel_q]) begin
            result_count   <= count_inc;
            result_timeout <= 1'b0;
            result_valid   <= 1'b1;
            state          <= T_DONE;
          end else if (sat_hit(count_inc)) begin
            result_count   <= '1;
            result_timeout <= 1'b1;
            result_valid   <= 1'b1;
            state          <= T_DONE;
          end else begin
            count <= count_inc;
          end
        end
        T_DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= T_IDLE;
          end
        end
        default: begin
          state <= T_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_sensor_bank.sv
module tb_light_sensor_bank;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // Bank A: 2 channels, 16-cycle debounce, 24-bit counter.
  logic [1:0]  sensor_a, on_a, rise_a, fall_a;
  logic        start_a, busy_a, valid_a, ready_a, to_a;
  logic [0:0]  sel_a;
  logic [23:0] cnt_a;

  // Bank B: 3 channels (so an out-of-range select is encodable), bypassed
  // debounce, 8-bit counter.
  logic [2:0]  sensor_b, on_b, rise_b, fall_b;
  logic        start_b, busy_b, valid_b, ready_b, to_b;
  logic [1:0]  sel_b;
  logic [7:0]  cnt_b;

  light_sensor_bank #(
    .CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .COUNT_W(24)
  ) dut_a (
    .clk(clk), .resetn(resetn), .sensor(sensor_a), .on(on_a), .rise(rise_a),
    .fall(fall_a), .start(start_a), .chan_sel(sel_a), .busy(busy_a),
    .result_valid(valid_a), .result_ready(ready_a), .result_count(cnt_a),
    .result_timeout(to_a)
  );

  light_sensor_bank #(
    .CHANNELS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .COUNT_W(8)
  ) dut_b (
    .clk(clk), .resetn(resetn), .sensor(sensor_b), .on(on_b), .rise(rise_b),
    .fall(fall_b), .start(start_b), .chan_sel(sel_b), .busy(busy_b),
    .result_valid(valid_b), .result_ready(ready_b), .result_count(cnt_b),
    .result_timeout(to_b)
  );

  typedef struct {
    int   sel;
    int   delay;
    int   exp_count;
    logic exp_to;
  } vec_t;

  typedef struct {
    logic [23:0] count;
    logic        to;
  } res_t;

  vec_t vecs[4];
  res_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a measurement on bank A, step the chosen sensor high 'delay' cycles
  // after the start is sampled, then collect and hold the result.
  task automatic run_meas(input int sel, input int delay, input int exp_c, input logic exp_t);
    res_t r;
    int   n;
    sel_a   = 1'(sel);
    start_a = 1'b1;
    if (delay == 0) sensor_a[sel] = 1'b1;
    sb.push_back('{24'(exp_c), exp_t});
    tick();
    start_a = 1'b0;
    check("meas_busy", 32'(busy_a), 1);
    for (int k = 1; k < delay; k++) tick();
    if (delay > 0) sensor_a[sel] = 1'b1;
    n = 0;
    while (!valid_a && n < 300) begin
      tick();
      n++;
    end
    r = sb.pop_front();
    check("meas_valid", 32'(valid_a), 1);
    for (int k = 0; k < 4; k++) begin
      check("meas_count", 32'(cnt_a), 32'(r.count));
      check("meas_timeout", 32'(to_a), 32'(r.to));
      check("meas_hold_valid", 32'(valid_a), 1);
      tick();
    end
    check("meas_count_held", 32'(cnt_a), 32'(r.count));
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    check("meas_valid_clr", 32'(valid_a), 0);
    check("meas_busy_clr", 32'(busy_a), 0);
    sensor_a[sel] = 1'b0;
    for (int k = 0; k < 25; k++) tick();
  endtask

  initial begin
    logic [1:0] acc;

    vecs[0] = '{1, 5, 23, 1'b0};
    vecs[1] = '{0, 0, 18, 1'b0};
    vecs[2] = '{0, 12, 30, 1'b0};
    vecs[3] = '{1, 40, 58, 1'b0};

    resetn   = 1'b0;
    sensor_a = '0; start_a = 1'b0; sel_a = '0; ready_a = 1'b0;
    sensor_b = '0; start_b = 1'b0; sel_b = '0; ready_b = 1'b0;
    tick(); tick();

    // Reset state.
    check("rst_a_chan", 32'({on_a, rise_a, fall_a}), 0);
    check("rst_a_timer", 32'({busy_a, valid_a, to_a, cnt_a}), 0);
    check("rst_b_all", 32'({on_b, rise_b, fall_b, busy_b, valid_b, to_b, cnt_b}), 0);
    @(negedge clk);
    resetn = 1'b1;
    tick(); tick();

    // Clean step on channel 0: 18-cycle latency, channel 1 untouched.
    sensor_a[0] = 1'b1;
    for (int k = 0; k < 17; k++) tick();
    check("step_on_early", 32'(on_a), 0);
    tick();
    check("step_on", 32'(on_a), 1);
    check("step_rise", 32'(rise_a), 1);
    tick();
    check("step_rise_width", 32'(rise_a), 0);
    sensor_a[0] = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    check("fall_on_early", 32'(on_a), 1);
    tick();
    check("fall_on", 32'(on_a), 0);
    check("fall_pulse", 32'(fall_a), 1);
    tick();
    check("fall_width", 32'(fall_a), 0);

    // 10-cycle glitch on channel 1 must be filtered.
    acc = '0;
    sensor_a[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      acc |= {on_a[1] | rise_a[1], fall_a[1]};
    end
    sensor_a[1] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      acc |= {on_a[1] | rise_a[1], fall_a[1]};
    end
    check("glitch_ch1", 32'(acc), 0);

    // Table-driven latency measurements.
    for (int v = 0; v < 4; v++)
      run_meas(vecs[v].sel, vecs[v].delay, vecs[v].exp_count, vecs[v].exp_to);

    // Bypassed debounce: on follows the synchroniser, 2-cycle latency.
    sensor_b[2] = 1'b1;
    tick();
    check("byp_on_early", 32'(on_b), 0);
    tick();
    check("byp_on", 32'(on_b), 4);
    check("byp_rise", 32'(rise_b), 4);
    tick();
    check("byp_rise_width", 32'(rise_b), 0);
    sensor_b[2] = 1'b0;
    tick(); tick();
    check("byp_off", 32'(on_b), 0);
    check("byp_fall", 32'(fall_b), 4);
    tick(); tick();

    // Saturation on 8-bit counter, with start pulses while busy.
    sel_b   = 2'd0;
    start_b = 1'b1;
    tick();
    check("sat_busy", 32'(busy_b), 1);
    for (int k = 1; k <= 254; k++) begin
      start_b = (k % 50 == 0);
      sel_b   = 2'd1;
      tick();
    end
    start_b = 1'b0;
    check("sat_valid_early", 32'(valid_b), 0);
    check("sat_busy_mid", 32'(busy_b), 1);
    tick();
    check("sat_valid", 32'(valid_b), 1);
    check("sat_count", 32'(cnt_b), 255);
    check("sat_timeout", 32'(to_b), 1);
    ready_b = 1'b1;
    start_b = 1'b1;
    sel_b   = 2'd0;
    tick();
    ready_b = 1'b0;
    start_b = 1'b0;
    check("done_start_ignored", 32'({busy_b, valid_b}), 0);
    tick();

    // Out-of-range channel select completes at once with timeout.
    sel_b   = 2'd3;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("bad_sel_valid", 32'(valid_b), 1);
    check("bad_sel_count", 32'(cnt_b), 0);
    check("bad_sel_timeout", 32'(to_b), 1);
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    check("bad_sel_clr", 32'(valid_b), 0);

    // Reset in the middle of a measurement.
    sel_a   = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check("mid_busy", 32'(busy_a), 1);
    resetn = 1'b0;
    sensor_a[0] = 1'b1;
    #1;
    check("async_rst_timer", 32'({busy_a, valid_a, to_a, cnt_a}), 0);
    check("async_rst_chan", 32'({on_a, rise_a, fall_a}), 0);
    tick();
    @(negedge clk);
    resetn = 1'b1;
    // Sensor held high through reset: on after 18 cycles, one rise.
    for (int k = 0; k < 17; k++) tick();
    check("post_rst_on_early", 32'(on_a), 0);
    tick();
    check("post_rst_on", 32'(on_a), 1);
    check("post_rst_rise", 32'(rise_a), 1);
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      acc |= rise_a;
    end
    check("post_rst_single_rise", 32'(acc), 0);
    run_meas(1, 3, 21, 1'b0);
    sensor_a = '0;
    for (int k = 0; k < 25; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
